// File: rtl/ptp_sync_tx_pkg.sv
// Shared PTP / GMII framing constants and FSM state type for the Sync
// transmitter. The CRC constants are also meant for a future FCS checker.
package ptp_sync_tx_pkg;

  localparam logic [15:0] PTP_ETHERTYPE  = 16'h88F7;
  localparam logic [47:0] PTP_MCAST_MAC  = 48'h01_1B_19_00_00_00;
  localparam logic [3:0]  PTP_MSG_SYNC   = 4'h0;
  localparam logic [3:0]  PTP_VERSION    = 4'h2;
  localparam logic [15:0] PTP_SYNC_LEN   = 16'd44;

  localparam logic [7:0]  GMII_PREAMBLE  = 8'h55;
  localparam logic [7:0]  GMII_SFD       = 8'hD5;
  localparam int          PREAMBLE_LEN   = 7;
  localparam int          FRAME_DATA_LEN = 60;
  localparam int          FCS_LEN        = 4;

  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  // Bit-reverse a 32-bit word; used to derive the reflected polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/ptp_sync_tx_crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one data
// byte, data bits consumed LSB first.
module crc32_d8
  import ptp_sync_tx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  // Shift the eight data bits through the reflected LFSR
  always_comb begin
    logic [31:0] c;
    logic        fb;
    c = crc_i;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ data_i[b];
      c  = c >> 1;
      if (fb) c = c ^ POLY_REFL;
    end
    crc_o = c;
  end

endmodule

// File: rtl/ptp_sync_tx.sv
// GMII transmitter for untagged Ethernet II one-step PTPv2 Sync frames.
// One byte per gmii_clk; originTimestamp latched as the SFD is launched.
module ptp_sync_tx
  import ptp_sync_tx_pkg::*;
#(
  parameter logic [47:0] SRC_MAC      = 48'h00_0A_35_00_00_01,
  parameter logic [63:0] CLOCK_ID     = 64'h000A35FFFE000001,
  parameter logic [15:0] PORT_NUM     = 16'h0001,
  parameter logic [7:0]  DOMAIN       = 8'h00,
  parameter logic [7:0]  LOG_INTERVAL = 8'h00,
  parameter int          IFG_BYTES    = 12
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        send_req,
  input  logic [31:0] time_ptp_ns,
  input  logic [47:0] time_ptp_sec,
  output logic        tx_gmii_ctrl,
  output logic [7:0]  tx_gmii_data,
  output logic        busy,
  output logic [15:0] seq_id,
  output logic        sent,
  output logic [79:0] sent_ts
);

  localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] DATA_LAST = 6'(FRAME_DATA_LEN - 1);
  localparam logic [5:0] FCS_LAST  = 6'(FCS_LEN - 1);
  localparam logic [5:0] IFG_LAST  = 6'(IFG_BYTES - 1);

  tx_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic [31:0] crc_q, crc_d;
  logic [79:0] ts_q, ts_d;
  logic [15:0] seq_q, seq_d;
  logic        ctrl_q, ctrl_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;
  logic [79:0] sent_ts_q, sent_ts_d;

  logic [7:0]  field_byte;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic        ifg_exit;

  assign ifg_exit = (state_q == ST_IFG) && (cnt_q == IFG_LAST);
  assign fcs_word = ~crc_q;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (field_byte),
    .crc_o  (crc_next)
  );

  // Frame field multiplexer: DATA byte for the current byte index
  always_comb begin
    int idx;
    idx = int'(cnt_q);
    field_byte = 8'h00;
    if (idx < 6)        field_byte = PTP_MCAST_MAC[8*(5-idx) +: 8];
    else if (idx < 12)  field_byte = SRC_MAC[8*(11-idx) +: 8];
    else if (idx < 14)  field_byte = PTP_ETHERTYPE[8*(13-idx) +: 8];
    else if (idx == 14) field_byte = {4'h0, PTP_MSG_SYNC};
    else if (idx == 15) field_byte = {4'h0, PTP_VERSION};
    else if (idx < 18)  field_byte = PTP_SYNC_LEN[8*(17-idx) +: 8];
    else if (idx == 18) field_byte = DOMAIN;
    else if (idx < 34)  field_byte = 8'h00;
    else if (idx < 42)  field_byte = CLOCK_ID[8*(41-idx) +: 8];
    else if (idx < 44)  field_byte = PORT_NUM[8*(43-idx) +: 8];
    else if (idx < 46)  field_byte = seq_q[8*(45-idx) +: 8];
    else if (idx == 46) field_byte = 8'h00;
    else if (idx == 47) field_byte = LOG_INTERVAL;
    else if (idx < 54)  field_byte = ts_q[32 + 8*(53-idx) +: 8];
    else if (idx < 58)  field_byte = ts_q[8*(57-idx) +: 8];
    else                field_byte = 8'h00;
  end

  // Next-state logic for the frame sequencer and the one-deep request queue
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (send_req && enable) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
      ST_SFD: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
      ST_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = (enable && (pending_q || send_req)) ? ST_PRE : ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!enable) pending_d = 1'b0;
    else if (send_req && (state_q != ST_IDLE)) pending_d = 1'b1;
    if (ifg_exit) pending_d = 1'b0;
  end

  // Registered GMII byte, CRC accumulation, timestamp latch and end-of-frame bookkeeping
  always_comb begin
    ctrl_d    = 1'b0;
    data_d    = 8'h00;
    crc_d     = crc_q;
    ts_d      = ts_q;
    seq_d     = seq_q;
    sent_d    = 1'b0;
    sent_ts_d = sent_ts_q;
    busy_d    = (state_d != ST_IDLE);
    unique case (state_q)
      ST_PRE: begin
        ctrl_d = 1'b1;
        data_d = GMII_PREAMBLE;
      end
      ST_SFD: begin
        ctrl_d = 1'b1;
        data_d = GMII_SFD;
        ts_d   = {time_ptp_sec, time_ptp_ns};
        crc_d  = CRC32_INIT;
      end
      ST_DATA: begin
        ctrl_d = 1'b1;
        data_d = field_byte;
        crc_d  = crc_next;
      end
      ST_FCS: begin
        ctrl_d = 1'b1;
        data_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
      end
      ST_IFG: begin
        if (cnt_q == 6'd0) begin
          sent_d    = 1'b1;
          sent_ts_d = ts_q;
          seq_d     = seq_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Datapath and output registers; reset clears the line at once
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      crc_q     <= CRC32_INIT;
      ts_q      <= '0;
      seq_q     <= '0;
      ctrl_q    <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      sent_ts_q <= '0;
    end else begin
      crc_q     <= crc_d;
      ts_q      <= ts_d;
      seq_q     <= seq_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      sent_ts_q <= sent_ts_d;
    end
  end

  assign tx_gmii_ctrl = ctrl_q;
  assign tx_gmii_data = data_q;
  assign busy         = busy_q;
  assign seq_id       = seq_q;
  assign sent         = sent_q;
  assign sent_ts      = sent_ts_q;

endmodule

// File: tb/tb_ptp_sync_tx.sv
// Directed self-checking bench for ptp_sync_tx. Outputs are logged on the
// falling edge and compared against a locally built frame and CRC model.
module tb_ptp_sync_tx;

  logic        gmii_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        send_req;
  logic [31:0] time_ptp_ns;
  logic [47:0] time_ptp_sec;
  logic        tx_gmii_ctrl;
  logic [7:0]  tx_gmii_data;
  logic        busy;
  logic [15:0] seq_id;
  logic        sent;
  logic [79:0] sent_ts;

  ptp_sync_tx dut (
    .gmii_clk     (gmii_clk),
    .rst          (rst),
    .enable       (enable),
    .send_req     (send_req),
    .time_ptp_ns  (time_ptp_ns),
    .time_ptp_sec (time_ptp_sec),
    .tx_gmii_ctrl (tx_gmii_ctrl),
    .tx_gmii_data (tx_gmii_data),
    .busy         (busy),
    .seq_id       (seq_id),
    .sent         (sent),
    .sent_ts      (sent_ts)
  );

  always #5 gmii_clk = ~gmii_clk;

  int checks = 0;
  int errors = 0;

  logic       ctrlLog [0:399];
  logic [7:0] dataLog [0:399];
  logic       sentLog [0:399];
  int         startIdx [0:7];
  int         nStarts;
  int         nHigh;
  int         nSent;
  int         idleDirty;

  logic [479:0] expData;
  logic [31:0]  expFcs;

  // Constant header bytes 0..43 of the Sync frame with default parameters
  logic [7:0] hdr [0:43] = '{
    8'h01, 8'h1B, 8'h19, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01,
    8'h88, 8'hF7, 8'h00, 8'h02, 8'h00, 8'h2C,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h0A, 8'h35, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h01,
    8'h00, 8'h01
  };

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle request; returns at the falling edge after the sampling edge
  task automatic applyStimulus();
    @(negedge gmii_clk);
    send_req = 1'b1;
    @(negedge gmii_clk);
    send_req = 1'b0;
  endtask

  // Log n cycles; optional requests at p0..p2, enable drop, ns ramp of +8
  task automatic recordCycles(input int n, input bit ramp, input int p0, input int p1,
                              input int p2, input int enOffAt);
    for (int i = 0; i < n; i++) begin
      send_req = (i == p0) || (i == p1) || (i == p2);
      if (enOffAt >= 0 && i >= enOffAt) enable = 1'b0;
      if (ramp) time_ptp_ns = time_ptp_ns + 32'd8;
      @(negedge gmii_clk);
      ctrlLog[i] = tx_gmii_ctrl;
      dataLog[i] = tx_gmii_data;
      sentLog[i] = sent;
    end
    send_req = 1'b0;
  endtask

  task automatic scanLog(input int n);
    logic prev;
    prev = 1'b0;
    nStarts = 0; nHigh = 0; nSent = 0; idleDirty = 0;
    for (int i = 0; i < n; i++) begin
      if (ctrlLog[i] === 1'b1 && prev !== 1'b1) begin
        if (nStarts < 8) startIdx[nStarts] = i;
        nStarts++;
      end
      if (ctrlLog[i] === 1'b1) nHigh++;
      if (ctrlLog[i] !== 1'b1 && dataLog[i] !== 8'h00) idleDirty++;
      if (sentLog[i] === 1'b1) nSent++;
      prev = ctrlLog[i];
    end
  endtask

  task automatic buildExpected(input logic [15:0] seq, input logic [47:0] sec, input logic [31:0] ns);
    logic [7:0]  d [0:59];
    logic [31:0] crc;
    for (int k = 0; k < 44; k++) d[k] = hdr[k];
    d[44] = seq[15:8];
    d[45] = seq[7:0];
    d[46] = 8'h00;
    d[47] = 8'h00;
    for (int k = 0; k < 6; k++) d[48+k] = sec[8*(5-k) +: 8];
    for (int k = 0; k < 4; k++) d[54+k] = ns[8*(3-k) +: 8];
    d[58] = 8'h00;
    d[59] = 8'h00;
    crc = 32'hFFFFFFFF;
    expData = '0;
    for (int k = 0; k < 60; k++) begin
      expData = {expData[471:0], d[k]};
      crc = crc ^ {24'h0, d[k]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    expFcs = {crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
  endtask

  task automatic checkFrameAt(input string tag, input int s, input logic [15:0] seq,
                              input logic [47:0] sec, input logic [31:0] ns);
    logic [63:0]  pre;
    logic [479:0] dat;
    logic [31:0]  fcs;
    int           run;
    buildExpected(seq, sec, ns);
    pre = '0; dat = '0; fcs = '0;
    for (int k = 0; k < 8; k++)  pre = {pre[55:0], dataLog[s+k]};
    for (int k = 0; k < 60; k++) dat = {dat[471:0], dataLog[s+8+k]};
    for (int k = 0; k < 4; k++)  fcs = {fcs[23:0], dataLog[s+68+k]};
    run = 0;
    while (s + run < 400 && ctrlLog[s+run] === 1'b1) run++;
    checkOutput({tag, " preamble/SFD"}, 512'(pre), 512'(64'h55555555555555D5));
    checkOutput({tag, " data"}, 512'(dat), 512'(expData));
    checkOutput({tag, " FCS"}, 512'(fcs), 512'(expFcs));
    checkOutput({tag, " ctrl run"}, 512'(run), 512'(72));
    checkOutput({tag, " tail ctrl/data/sent"},
                512'({ctrlLog[s+72], dataLog[s+72], sentLog[s+72]}), 512'({1'b0, 8'h00, 1'b1}));
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge gmii_clk);
      n++;
    end
    checkOutput("idle wait busy", 512'(busy), 512'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; send_req = 1'b0;
    time_ptp_ns = 32'h0; time_ptp_sec = 48'h0;
    repeat (3) @(negedge gmii_clk);
    checkOutput("reset outputs",
                512'({tx_gmii_ctrl, tx_gmii_data, busy, seq_id, sent, sent_ts}), 512'(0));
    rst = 1'b0;
    enable = 1'b1;

    // Single frame
    $display("[TB] single frame");
    time_ptp_sec = 48'h1; time_ptp_ns = 32'h3B9AC9FF;
    applyStimulus();
    checkOutput("launch busy/ctrl", 512'({busy, tx_gmii_ctrl}), 512'(2'b10));
    recordCycles(100, 1'b0, -1, -1, -1, -1);
    scanLog(100);
    checkOutput("single start count", 512'(nStarts), 512'(1));
    checkOutput("single first 0x55 index", 512'(startIdx[0]), 512'(0));
    checkOutput("single ctrl high total", 512'(nHigh), 512'(72));
    checkOutput("single sent pulses", 512'(nSent), 512'(1));
    checkOutput("single idle data zero", 512'(idleDirty), 512'(0));
    checkFrameAt("single", 0, 16'h0000, 48'h1, 32'h3B9AC9FF);
    checkOutput("single seq_id", 512'(seq_id), 512'(16'h0001));
    checkOutput("single sent_ts", 512'(sent_ts), 512'({48'h1, 32'h3B9AC9FF}));
    checkOutput("single busy after", 512'(busy), 512'(0));

    // Latency and timestamp capture with ns ramping by 8 per cycle
    $display("[TB] latency/timestamp");
    time_ptp_sec = 48'h0000_0000_0002; time_ptp_ns = 32'h0000_1000;
    applyStimulus();
    recordCycles(100, 1'b1, -1, -1, -1, -1);
    scanLog(100);
    checkOutput("latency first 0x55 index", 512'(startIdx[0]), 512'(0));
    checkOutput("latency sfd index", 512'({ctrlLog[7], dataLog[7]}), 512'({1'b1, 8'hD5}));
    checkFrameAt("latency", 0, 16'h0001, 48'h2, 32'h0000_1040);
    checkOutput("latency sent_ts", 512'(sent_ts), 512'({48'h2, 32'h0000_1040}));
    waitIdle();

    // Back-to-back with coalesced requests after a fresh reset
    $display("[TB] back-to-back");
    @(negedge gmii_clk); rst = 1'b1;
    @(negedge gmii_clk); rst = 1'b0;
    checkOutput("b2b seq after reset", 512'(seq_id), 512'(0));
    time_ptp_sec = 48'h0000_0000_ABCD; time_ptp_ns = 32'h1234_5678;
    applyStimulus();
    recordCycles(200, 1'b0, 10, 30, 50, -1);
    scanLog(200);
    checkOutput("b2b frame count", 512'(nStarts), 512'(2));
    checkOutput("b2b spacing", 512'(startIdx[1] - startIdx[0]), 512'(84));
    checkFrameAt("b2b frame0", startIdx[0], 16'h0000, 48'hABCD, 32'h1234_5678);
    checkFrameAt("b2b frame1", startIdx[1], 16'h0001, 48'hABCD, 32'h1234_5678);
    checkOutput("b2b seq_id", 512'(seq_id), 512'(16'h0002));
    waitIdle();

    // enable drop discards the pending request and later requests
    $display("[TB] enable low");
    applyStimulus();
    recordCycles(200, 1'b0, 10, 100, 120, 20);
    scanLog(200);
    checkOutput("enable frame count", 512'(nStarts), 512'(1));
    checkOutput("enable ctrl high total", 512'(nHigh), 512'(72));
    checkFrameAt("enable", 0, 16'h0002, 48'hABCD, 32'h1234_5678);
    checkOutput("enable seq_id", 512'(seq_id), 512'(16'h0003));
    enable = 1'b1;
    waitIdle();

    // Sequence id wrap
    $display("[TB] seq wrap");
    @(negedge gmii_clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge gmii_clk);
    release dut.seq_q;
    @(negedge gmii_clk);
    checkOutput("wrap seq preset", 512'(seq_id), 512'(16'hFFFF));
    applyStimulus();
    recordCycles(200, 1'b0, 10, -1, -1, -1);
    scanLog(200);
    checkOutput("wrap frame count", 512'(nStarts), 512'(2));
    checkFrameAt("wrap FFFF", startIdx[0], 16'hFFFF, 48'hABCD, 32'h1234_5678);
    checkFrameAt("wrap 0000", startIdx[1], 16'h0000, 48'hABCD, 32'h1234_5678);
    checkOutput("wrap seq_id", 512'(seq_id), 512'(16'h0001));
    waitIdle();

    // Asynchronous reset in the middle of DATA
    $display("[TB] reset mid-DATA");
    applyStimulus();
    recordCycles(20, 1'b0, -1, -1, -1, -1);
    checkOutput("mid-data ctrl before reset", 512'(ctrlLog[19]), 512'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs", 512'({tx_gmii_ctrl, tx_gmii_data, busy, seq_id, sent}), 512'(0));
    @(negedge gmii_clk);
    rst = 1'b0;
    time_ptp_sec = 48'h0000_0000_0007; time_ptp_ns = 32'h0000_0042;
    applyStimulus();
    recordCycles(100, 1'b0, -1, -1, -1, -1);
    scanLog(100);
    checkOutput("post-reset frame count", 512'(nStarts), 512'(1));
    checkFrameAt("post-reset", 0, 16'h0000, 48'h7, 32'h0000_0042);
    checkOutput("post-reset seq_id", 512'(seq_id), 512'(16'h0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
